// File: rtl/spi_wb_bridge_slave.sv
// spi_wb_bridge_slave
// SPI mode-0 slave that turns framed SPI transfers into Wishbone byte
// cycles. The first byte of a frame is a command: bit 7 selects write (1)
// or read (0), and bits 6:0 give the start address. The address
// auto-increments and wraps within 7 bits.
// Reads are prefetched one byte ahead, so a turnaround byte follows the
// command byte before the first read data byte.

module spi_wb_bridge_slave #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       spi_sck_i,
    input  logic       spi_cs_n_i,
    input  logic       spi_mosi_i,
    output logic       spi_miso_o,
    output logic       spi_miso_oe_o,
    output logic [7:0] wb_adr_o,
    output logic [7:0] wb_dat_o,
    input  logic [7:0] wb_dat_i,
    output logic       wb_we_o,
    output logic       wb_cyc_o,
    output logic       wb_stb_o,
    input  logic       wb_ack_i,
    input  logic       wb_err_i,
    output logic       err_o
);

    // state | meaning
    // IDLE  | CS deasserted, no frame in progress
    // CMD   | receiving command byte, MISO shifts {err, 7'b0}
    // TURN  | read turnaround byte, MISO 0x00 while first read completes
    // XFER  | data bytes: each byte is written, or read from the prefetch
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_TURN = 2'd2,
        ST_XFER = 2'd3
    } state_t;

    // synchronizers
    logic [2:0] sck_sync_q;
    logic [1:0] cs_sync_q;
    logic [1:0] mosi_sync_q;

    // frame side
    state_t     state_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] rx_q;
    logic [7:0] tx_q;
    logic       miso_q;
    logic       wr_q;
    logic [6:0] addr_q;

    // request handoff to the bus side (single-entry)
    logic       req_pend_q;
    logic       req_we_q;
    logic [6:0] req_adr_q;
    logic [7:0] req_dat_q;

    // bus side
    logic       cyc_q;
    logic       we_q;
    logic [6:0] wb_adr_q;
    logic [7:0] wb_dat_q;
    logic [7:0] tmo_q;
    logic [7:0] rd_buf_q;
    logic       err_q;
    logic       err_d;

    // decoded events
    logic       sck_rise;
    logic       sck_fall;
    logic       cs_act;
    logic [7:0] rx_byte;
    logic       byte_done;
    logic       first_bit;
    logic       cmd_done;
    logic       new_req;
    logic       new_req_we;
    logic [6:0] new_req_adr;
    logic [7:0] new_req_dat;
    logic       wb_term;
    logic       wb_fail;

    assign spi_miso_o    = miso_q;
    assign spi_miso_oe_o = ~cs_sync_q[1];
    assign wb_adr_o      = {1'b0, wb_adr_q};
    assign wb_dat_o      = wb_dat_q;
    assign wb_we_o       = we_q;
    assign wb_cyc_o      = cyc_q;
    assign wb_stb_o      = cyc_q;
    assign err_o         = err_q;

    // Bring the SPI pins into clk_i; CS resets to its inactive level so OE stays low.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sck_sync_q  <= 3'b000;
            cs_sync_q   <= 2'b11;
            mosi_sync_q <= 2'b00;
        end else begin
            sck_sync_q  <= {sck_sync_q[1:0], spi_sck_i};
            cs_sync_q   <= {cs_sync_q[0], spi_cs_n_i};
            mosi_sync_q <= {mosi_sync_q[0], spi_mosi_i};
        end
    end

    // Edge detection, byte boundaries and bus requests raised by the frame.
    always_comb begin
        sck_rise    = sck_sync_q[1] & ~sck_sync_q[2];
        sck_fall    = ~sck_sync_q[1] & sck_sync_q[2];
        cs_act      = ~cs_sync_q[1];
        rx_byte     = {rx_q[6:0], mosi_sync_q[1]};
        byte_done   = cs_act && (state_q != ST_IDLE) && sck_rise && (bit_cnt_q == 3'd7);
        first_bit   = cs_act && (state_q == ST_XFER) && sck_rise && (bit_cnt_q == 3'd0);
        cmd_done    = byte_done && (state_q == ST_CMD);
        new_req     = 1'b0;
        new_req_we  = 1'b0;
        new_req_adr = 7'd0;
        new_req_dat = 8'd0;
        if (cmd_done && !rx_byte[7]) begin
            // read of the start address, ready for the first data byte
            new_req     = 1'b1;
            new_req_adr = rx_byte[6:0];
        end else if (byte_done && (state_q == ST_XFER) && wr_q) begin
            new_req     = 1'b1;
            new_req_we  = 1'b1;
            new_req_adr = addr_q;
            new_req_dat = rx_byte;
        end else if (first_bit && !wr_q) begin
            // prefetch the byte that the following data byte will return
            new_req     = 1'b1;
            new_req_adr = addr_q + 7'd1;
        end
    end

    // Bus termination decode; error beats ack, and silence past the limit counts as error.
    always_comb begin
        wb_term = cyc_q && (wb_ack_i || wb_err_i || (tmo_q == 8'd0));
        wb_fail = cyc_q && (wb_err_i || (!wb_ack_i && (tmo_q == 8'd0)));
        err_d   = err_q;
        if (cmd_done) begin
            err_d = 1'b0;
        end
        if (wb_fail) begin
            err_d = 1'b1;
        end
    end

    // Frame FSM: bit counting, MOSI shift-in, MISO shift-out and address tracking.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 3'd0;
            rx_q      <= 8'd0;
            tx_q      <= 8'd0;
            miso_q    <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= 7'd0;
        end else if (!cs_act) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 3'd0;
            rx_q      <= 8'd0;
            tx_q      <= 8'd0;
            miso_q    <= 1'b0;
        end else if (state_q == ST_IDLE) begin
            // MSB of the command reply goes out before the first SCK edge
            state_q   <= ST_CMD;
            bit_cnt_q <= 3'd0;
            miso_q    <= err_q;
            tx_q      <= 8'd0;
        end else if (sck_rise) begin
            rx_q      <= rx_byte;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                case (state_q)
                    ST_CMD: begin
                        wr_q    <= rx_byte[7];
                        addr_q  <= rx_byte[6:0];
                        tx_q    <= 8'd0;
                        state_q <= rx_byte[7] ? ST_XFER : ST_TURN;
                    end
                    ST_TURN: begin
                        tx_q    <= rd_buf_q;
                        state_q <= ST_XFER;
                    end
                    default: begin
                        if (wr_q) begin
                            addr_q <= addr_q + 7'd1;
                            tx_q   <= 8'd0;
                        end else begin
                            tx_q   <= rd_buf_q;
                        end
                    end
                endcase
            end else if ((state_q == ST_XFER) && !wr_q && (bit_cnt_q == 3'd0)) begin
                addr_q <= addr_q + 7'd1;
            end
        end else if (sck_fall) begin
            miso_q <= tx_q[7];
            tx_q   <= {tx_q[6:0], 1'b0};
        end
    end

    // Wishbone master: one cycle at a time, queued request waits for the bus to go idle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            req_pend_q <= 1'b0;
            req_we_q   <= 1'b0;
            req_adr_q  <= 7'd0;
            req_dat_q  <= 8'd0;
            cyc_q      <= 1'b0;
            we_q       <= 1'b0;
            wb_adr_q   <= 7'd0;
            wb_dat_q   <= 8'd0;
            tmo_q      <= 8'd0;
            rd_buf_q   <= 8'd0;
            err_q      <= 1'b0;
        end else begin
            err_q <= err_d;
            if (new_req) begin
                req_pend_q <= 1'b1;
                req_we_q   <= new_req_we;
                req_adr_q  <= new_req_adr;
                req_dat_q  <= new_req_dat;
            end else if (req_pend_q && !cyc_q) begin
                req_pend_q <= 1'b0;
            end
            if (cyc_q) begin
                if (wb_term) begin
                    cyc_q <= 1'b0;
                    if (!we_q) begin
                        rd_buf_q <= wb_fail ? 8'hFF : wb_dat_i;
                    end
                end else begin
                    tmo_q <= tmo_q - 8'd1;
                end
            end else if (req_pend_q) begin
                cyc_q    <= 1'b1;
                we_q     <= req_we_q;
                wb_adr_q <= req_adr_q;
                wb_dat_q <= req_dat_q;
                tmo_q    <= 8'(TIMEOUT);
            end
        end
    end

endmodule
